div32x32: RTL and testbench
===========================

DIV32X32 -- requirements
Module: div32x32

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have port: start  input  1  request a division; accepted only in IDLE.
REQ-004 SHALL have port: a  input  32  unsigned dividend, sampled on the accepting edge.
REQ-005 SHALL have port: b  input  32  unsigned divisor, sampled on the accepting edge.
REQ-006 SHALL have port: busy  output  1  high while a division is in progress.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when results are valid.
REQ-008 SHALL have port: quotient  output  32  registered quotient, held until the next accepted start.
REQ-009 SHALL have port: remainder  output  32  registered remainder, held until the next accepted start.
REQ-010 SHALL have port: dbz  output  1  divide-by-zero flag, valid with done, held until the next accepted start.

Function
REQ-011 SHALL implement an unsigned restoring divider producing one quotient bit per clock, MSB first.
REQ-012 SHALL use FSM states IDLE, CALC and DONE.
REQ-013 IDLE: start=1 at an edge SHALL latch a and b, clear the partial remainder, set the 5-bit iteration count to 0, clear dbz, and go to CALC.
REQ-014 CALC, each edge: remainder = {rem[30:0], dvd[31]}; if that value is >= b, subtract b and shift in quotient bit 1, else shift in 0; count increments.
REQ-015 CALC SHALL use a 33-bit compare/subtract so that no overflow is lost.
REQ-016 CALC at count==31 SHALL perform the final iteration and go to DONE; count SHALL NOT wrap in normal operation.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-018 busy SHALL be 1 in CALC only; done SHALL be 1 in DONE only.
REQ-019 Latency: start accepted at edge N gives done=1 in the cycle following edge N+32.
REQ-020 start in CALC or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-021 a and b SHALL be don't-care after the accepting edge.
REQ-022 quotient and remainder SHALL change only at the final CALC edge, or at a zero-detect completion.
REQ-023 Without zero detect, b=0 SHALL run all 32 iterations and give quotient=FFFFFFFF, remainder=a, dbz=0.

Reset
REQ-024 reset=0 at any edge, including mid-CALC, SHALL force IDLE and abort any operation in progress.
REQ-025 Reset SHALL clear busy, done, quotient, remainder, dbz and the iteration count to 0.
REQ-026 reset=0 SHALL override a simultaneous start; start is honoured only when reset=1.

Configuration
REQ-027 The macro DIV32X32_ZERO_DETECT_EN SHALL control divide-by-zero detection.
REQ-028 With the macro defined, start with b=0 in IDLE SHALL go directly to DONE.
REQ-029 That zero-detect completion SHALL load quotient=FFFFFFFF, remainder=a, dbz=1, so done appears in the cycle after edge N.
REQ-030 Without the macro, dbz SHALL be tied to 0 and b=0 SHALL follow REQ-023.

Structure
REQ-031 Package div32x32_pkg SHALL hold the state enum (IDLE, CALC, DONE), DATA_W=32 and CNT_W=5.
REQ-032 Control SHALL be split into sub-module div32x32_fsm, which owns state, count, busy, done and the datapath load/shift enables.
REQ-033 The registers and the subtractor SHALL reside in div32x32.

Verification
REQ-034 a=100, b=7, start at edge N -> done in the cycle after edge N+32, quotient=14, remainder=2, dbz=0.
REQ-035 a=FFFFFFFF, b=1 -> quotient=FFFFFFFF, remainder=0; then a=FFFFFFFF, b=FFFFFFFF -> quotient=1, remainder=0.
REQ-036 a=5, b=10 -> quotient=0, remainder=5; second start pulsed during CALC -> no second done.
REQ-037 a=1234, b=0 -> with macro: done after 1 cycle, dbz=1, quotient=FFFFFFFF, remainder=1234; without macro: done after 33 cycles with the same quotient and remainder, dbz=0.
REQ-038 a=100, b=7, reset=0 at the edge 10 edges after acceptance -> busy=0, all outputs 0, no done; a new start then completes normally.

Source files
------------

// File: rtl/div32x32_pkg.sv
// rtl/div32x32_pkg.sv - shared types and widths for the 32/32 unsigned divider
//
// Holds the controller state encoding and the datapath/iteration widths
// used by div32x32 and div32x32_fsm.
package div32x32_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div32x32_fsm.sv
// rtl/div32x32_fsm.sv - controller for the restoring divider
//
// Owns the state register, the iteration count and the busy/done flags,
// and produces the datapath enables.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-low reset
//   start     in   division request, honoured only in IDLE
//   zero_div  in   divisor is zero and zero detection is built in (else 0)
//   busy      out  registered, high in CALC
//   done      out  registered, high for the single DONE cycle
//   load      out  operands are accepted at this edge
//   zero_load out  accepted operands take the zero-detect shortcut
//   shift     out  one quotient bit is produced at this edge
//   last      out  this edge produces the final quotient bit
module div32x32_fsm
    import div32x32_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic zero_div,
    output logic busy,
    output logic done,
    output logic load,
    output logic zero_load,
    output logic shift,
    output logic last
);

    state_t             state;
    logic [CNT_W-1:0]   count;

    assign load      = (state == IDLE) && start;
    assign zero_load = load && zero_div;
    assign shift     = (state == CALC);
    assign last      = (state == CALC) && (count == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                        if (zero_div) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    // Count stops at its last value instead of wrapping;
                    // it is reloaded on the next accepted start.
                    if (count == {CNT_W{1'b1}}) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/div32x32.sv
// rtl/div32x32.sv - 32/32 unsigned restoring divider, one quotient bit per clock
//
// Optional feature macro: DIV32X32_ZERO_DETECT_EN. When defined, a zero
// divisor completes immediately with dbz=1; otherwise dbz is tied low and a
// zero divisor runs the full 32 iterations.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   start      in   division request, accepted only when idle
//   a          in   dividend, sampled on the accepting edge
//   b          in   divisor, sampled on the accepting edge
//   busy       out  high while iterating
//   done       out  one-cycle pulse when results are valid
//   quotient   out  result, held until the next completion
//   remainder  out  result, held until the next completion
//   dbz        out  divide-by-zero flag
module div32x32
    import div32x32_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              dbz
);

    logic              load;
    logic              zero_load;
    logic              shift;
    logic              last;
    logic              zero_div;

    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dvsr;
    logic [DATA_W-1:0] rem_q;

    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;
    logic              qbit;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;

`ifdef DIV32X32_ZERO_DETECT_EN
    assign zero_div = (b == '0);
`else
    assign zero_div = 1'b0;
`endif

    div32x32_fsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .zero_div  (zero_div),
        .busy      (busy),
        .done      (done),
        .load      (load),
        .zero_load (zero_load),
        .shift     (shift),
        .last      (last)
    );

    // The partial remainder keeps its top bit in the trial value so the
    // compare never loses an overflowed bit; the subtracted result always
    // fits back into DATA_W bits because the remainder stays below dvsr.
    always_comb begin
        trial    = {rem_q, dvd[DATA_W-1]};
        diff     = trial - {1'b0, dvsr};
        qbit     = (trial >= {1'b0, dvsr});
        rem_next = qbit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_next = {dvd[DATA_W-2:0], qbit};
    end

    // Dividend register doubles as the quotient shift register: quotient
    // bits enter at the LSB as dividend bits leave at the MSB.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dvd       <= '0;
            dvsr      <= '0;
            rem_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (load) begin
            dvd   <= a;
            dvsr  <= b;
            rem_q <= '0;
            if (zero_load) begin
                quotient  <= '1;
                remainder <= a;
            end
        end else if (shift) begin
            dvd   <= quo_next;
            rem_q <= rem_next;
            if (last) begin
                quotient  <= quo_next;
                remainder <= rem_next;
            end
        end
    end

`ifdef DIV32X32_ZERO_DETECT_EN
    logic dbz_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            dbz_q <= 1'b0;
        end else if (load) begin
            dbz_q <= zero_load;
        end
    end

    assign dbz = dbz_q;
`else
    assign dbz = 1'b0;
`endif

endmodule

// File: tb/tb_div32x32.sv
// tb/tb_div32x32.sv - self-checking bench for div32x32
module tb_div32x32;

`ifdef DIV32X32_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dbz;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] prev_q = '0;
    logic [31:0] prev_r = '0;

    always #5 clk = ~clk;

    div32x32 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic, with b=0 defined as all-ones / a.
    task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input bit poke_start);
        logic [31:0] eq;
        logic [31:0] er;
        bit          ed;
        int          k;
        int          extra;
        eq = (bv == 0) ? 32'hFFFF_FFFF : av / bv;
        er = (bv == 0) ? av : av % bv;
        ed = ZD && (bv == 0);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        k = 0;
        while (!done && k < 40) begin
            if (k == 1) begin
                check("busy_calc", busy, 1);
                check("q_hold", quotient, prev_q);
                check("r_hold", remainder, prev_r);
                check("dbz_clr", dbz, 0);
            end
            if (poke_start && k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, ed ? 0 : 32);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("dbz", dbz, ed);
        check("busy_done", busy, 0);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        prev_q = eq;
        prev_r = er;
        if (poke_start) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (done) extra++;
            end
            check("no_queued_start", extra, 0);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; a = 32'd9; b = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", dbz, 0);
        start = 1'b0;
        reset = 1'b1;

        run_div(32'd100, 32'd7, 1'b0);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_div(32'd5, 32'd10, 1'b1);
        run_div(32'd1234, 32'd0, 1'b0);

        // Reset 10 edges after acceptance aborts the division.
        begin
            int dn;
            @(negedge clk);
            a = 32'd100; b = 32'd7; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (9) @(posedge clk);
            #1;
            reset = 1'b0;
            @(posedge clk); #1;
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_q", quotient, 0);
            check("abort_r", remainder, 0);
            check("abort_dbz", dbz, 0);
            reset = 1'b1;
            dn = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (done || busy) dn++;
            end
            check("abort_quiet", dn, 0);
            prev_q = '0;
            prev_r = '0;
        end
        run_div(32'd100, 32'd7, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 255);
                2: rb = ra >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_div(ra, rb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
